// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified instruction/data memory port of the multi-cycle
// core between two requesters: the core control path (fetch/load/store) and
// a debug/loader port. Only one access is in flight at a time. Each access
// walks IDLE -> ISSUE -> WAIT (MEM_LATENCY-1 cycles) -> DONE -> IDLE.
//
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN  defined   : round-robin on simultaneous requests
//                           undefined : fixed priority, core wins ties
//
// Parameters:
//   AW           address width
//   DW           data width
//   MEM_LATENCY  cycles from the mem_en cycle until mem_rdata is valid (1..15)
//
// Ports:
//   clk, rstn                    clock (rising edge), async active-low reset
//   c_req/c_we/c_addr/c_wdata    core request, held until c_gnt
//   c_gnt                        core accepted (combinational, IDLE only)
//   c_done/c_rdata               1-cycle completion pulse, read data on reads
//   d_*                          same set for the debug/loader port
//   mem_en/mem_we                memory command strobe (one cycle) and write
//   mem_addr/mem_wdata           registered command address and write data
//   mem_rdata                    memory read data, valid in the DONE cycle
//   busy                         high in every state other than IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_done,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    generate
        if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
            $error("mem_port_arbiter: MEM_LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic       OWN_CORE = 1'b0;
    localparam logic       OWN_DBG  = 1'b1;
    localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

    state_t        state, state_nxt;
    logic [3:0]    lat_cnt, lat_cnt_nxt;
    logic          owner, owner_nxt;
    logic          cmd_we, cmd_we_nxt;
    logic [AW-1:0] cmd_addr, cmd_addr_nxt;
    logic [DW-1:0] cmd_wdata, cmd_wdata_nxt;
    logic          grant;
    logic          pick_dbg;
    logic          done_now;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_winner;

    // Tie goes to whoever did not win the previous grant. last_winner starts
    // at debug so the first tie after reset is handed to the core.
    always_comb begin
        pick_dbg = d_req & (~c_req | (last_winner == OWN_CORE));
    end

    // Remember the winner of every grant, tie or not.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_winner <= OWN_DBG;
        end else if (grant) begin
            last_winner <= pick_dbg;
        end
    end
`else
    // Fixed priority: debug only wins when the core is not asking.
    always_comb begin
        pick_dbg = d_req & ~c_req;
    end
`endif

    // State and latched command. The command registers are cleared on reset
    // so mem_addr/mem_wdata read 0 while the block is held in reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            lat_cnt   <= 4'd0;
            owner     <= OWN_CORE;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_cnt_nxt;
            owner     <= owner_nxt;
            cmd_we    <= cmd_we_nxt;
            cmd_addr  <= cmd_addr_nxt;
            cmd_wdata <= cmd_wdata_nxt;
        end
    end

    // Next-state logic. Requests are only looked at in IDLE; the grant is
    // masked by rstn so a requester holding req during reset sees no gnt.
    always_comb begin
        state_nxt     = state;
        lat_cnt_nxt   = lat_cnt;
        owner_nxt     = owner;
        cmd_we_nxt    = cmd_we;
        cmd_addr_nxt  = cmd_addr;
        cmd_wdata_nxt = cmd_wdata;
        grant         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rstn && (c_req || d_req)) begin
                    grant         = 1'b1;
                    owner_nxt     = pick_dbg;
                    cmd_we_nxt    = pick_dbg ? d_we    : c_we;
                    cmd_addr_nxt  = pick_dbg ? d_addr  : c_addr;
                    cmd_wdata_nxt = pick_dbg ? d_wdata : c_wdata;
                    state_nxt     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                lat_cnt_nxt = LAT_LAST;
                state_nxt   = (MEM_LATENCY == 1) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                // Counter holds the number of cycles left before DONE.
                lat_cnt_nxt = lat_cnt - 4'd1;
                if (lat_cnt <= 4'd1) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign c_gnt     = grant & ~pick_dbg;
    assign d_gnt     = grant & pick_dbg;

    assign mem_en    = (state == ST_ISSUE);
    assign mem_we    = mem_en & cmd_we;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;

    // Read data is passed straight through from memory in the DONE cycle
    // and forced to 0 for writes and for the requester that does not own
    // the access.
    assign done_now  = (state == ST_DONE);
    assign c_done    = done_now & (owner == OWN_CORE);
    assign d_done    = done_now & (owner == OWN_DBG);
    assign c_rdata   = (c_done && !cmd_we) ? mem_rdata : '0;
    assign d_rdata   = (d_done && !cmd_we) ? mem_rdata : '0;

    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Instance "a" runs with MEM_LATENCY=1
// against a small behavioural memory; instance "b" runs with MEM_LATENCY=3
// against a fixed read-data pipeline. Completed accesses on "a" are matched
// against a queue of expected owner/read-data entries.
// Tie expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    logic        a_c_req, a_c_we, a_c_gnt, a_c_done;
    logic [31:0] a_c_addr, a_c_wdata, a_c_rdata;
    logic        a_d_req, a_d_we, a_d_gnt, a_d_done;
    logic [31:0] a_d_addr, a_d_wdata, a_d_rdata;
    logic        a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_c_req, b_c_we, b_c_gnt, b_c_done;
    logic [31:0] b_c_addr, b_c_wdata, b_c_rdata;
    logic        b_d_req, b_d_we, b_d_gnt, b_d_done;
    logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(1)) u_dut_a (
        .clk(clk), .rstn(rstn),
        .c_req(a_c_req), .c_we(a_c_we), .c_addr(a_c_addr), .c_wdata(a_c_wdata),
        .c_gnt(a_c_gnt), .c_done(a_c_done), .c_rdata(a_c_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_done(a_d_done), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(3)) u_dut_b (
        .clk(clk), .rstn(rstn),
        .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr), .c_wdata(b_c_wdata),
        .c_gnt(b_c_gnt), .c_done(b_c_done), .c_rdata(b_c_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_done(b_d_done), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory behind instance a: one-cycle read latency. Address 0x10 is
    // preloaded with 0xDEADBEEF; outside read-return cycles the data bus
    // carries a junk pattern so ungated read data is visible.
    logic [31:0] mem_a [0:63];

    always @(posedge clk) begin
        if (!rstn) begin
            mem_a[4]    <= 32'hDEAD_BEEF;
            a_mem_rdata <= 32'hA5A5_A5A5;
        end else begin
            if (a_mem_en && a_mem_we) begin
                mem_a[a_mem_addr[7:2]] <= a_mem_wdata;
            end
            if (a_mem_en && !a_mem_we) begin
                a_mem_rdata <= mem_a[a_mem_addr[7:2]];
            end else begin
                a_mem_rdata <= 32'hA5A5_A5A5;
            end
        end
    end

    // Memory behind instance b: three-cycle read pipeline returning
    // {16'hCAFE, addr[15:0]} for reads, junk otherwise.
    logic [31:0] b_pipe [0:2];

    always @(posedge clk) begin
        if (!rstn) begin
            b_pipe[0] <= 32'hA5A5_A5A5;
            b_pipe[1] <= 32'hA5A5_A5A5;
            b_pipe[2] <= 32'hA5A5_A5A5;
        end else begin
            b_pipe[0] <= (b_mem_en && !b_mem_we) ? {16'hCAFE, b_mem_addr[15:0]} : 32'hA5A5_A5A5;
            b_pipe[1] <= b_pipe[0];
            b_pipe[2] <= b_pipe[1];
        end
    end

    assign b_mem_rdata = b_pipe[2];

    typedef struct packed {
        logic        is_dbg;
        logic [31:0] rdata;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_ent;
    int  checks = 0;
    int  errors = 0;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic sb_push(input logic dbg, input logic [31:0] rdata);
        sb_t ent;
        ent.is_dbg = dbg;
        ent.rdata  = rdata;
        sb_q.push_back(ent);
    endtask

    // Scoreboard side of instance a: every done pulse must match the oldest
    // expected entry, and read data must be 0 whenever its port is not done.
    always @(negedge clk) begin
        if (rstn) begin
            if (a_c_done || a_d_done) begin
                if (sb_q.size() == 0) begin
                    check_output("sb_unexpected_done", {a_c_done, a_d_done}, 2'b00);
                end else begin
                    mon_ent = sb_q.pop_front();
                    check_output("sb_owner", a_d_done, mon_ent.is_dbg);
                    check_output("sb_rdata", a_d_done ? a_d_rdata : a_c_rdata, mon_ent.rdata);
                    check_output("sb_single_done", a_c_done & a_d_done, 1'b0);
                end
            end
            if (!a_c_done) check_output("c_rdata_idle", a_c_rdata, 32'h0);
            if (!a_d_done) check_output("d_rdata_idle", a_d_rdata, 32'h0);
        end
    end

    // One complete access on instance a, issued from IDLE with no competition.
    task automatic a_access(input logic dbg, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata);
        next_cycle();
        if (dbg) begin
            a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
        end else begin
            a_c_req = 1'b1; a_c_we = we; a_c_addr = addr; a_c_wdata = wdata;
        end
        sb_push(dbg, we ? 32'h0 : exp_rdata);
        sample();
        check_output("gnt_core", a_c_gnt, !dbg);
        check_output("gnt_dbg", a_d_gnt, dbg);
        check_output("busy_idle", a_busy, 1'b0);

        next_cycle();
        a_c_req = 1'b0;
        a_d_req = 1'b0;
        sample();
        check_output("issue_mem_en", a_mem_en, 1'b1);
        check_output("issue_mem_we", a_mem_we, we);
        check_output("issue_mem_addr", a_mem_addr, addr);
        if (we) check_output("issue_mem_wdata", a_mem_wdata, wdata);
        check_output("issue_busy", a_busy, 1'b1);

        next_cycle();
        sample();
        check_output("done_core", a_c_done, !dbg);
        check_output("done_dbg", a_d_done, dbg);
        check_output("done_mem_en", a_mem_en, 1'b0);
        check_output("done_mem_we", a_mem_we, 1'b0);

        next_cycle();
        sample();
        check_output("after_busy", a_busy, 1'b0);
        check_output("after_done", {a_c_done, a_d_done}, 2'b00);
    endtask

    task automatic pulse_reset();
        next_cycle();
        rstn = 1'b0;
        sample();
        check_output("rst_a_busy", a_busy, 1'b0);
        check_output("rst_a_mem_en", a_mem_en, 1'b0);
        next_cycle();
        rstn = 1'b1;
    endtask

    logic [2:0] exp_winner;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_winner = 3'b010;
`else
        exp_winner = 3'b000;
`endif
        a_c_req = 1'b1; a_c_we = 1'b0; a_c_addr = '0; a_c_wdata = '0;
        a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = '0; a_d_wdata = '0;
        b_c_req = 1'b0; b_c_we = 1'b0; b_c_addr = '0; b_c_wdata = '0;
        b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
        rstn = 1'b0;

        // Held in reset with a pending core request: everything quiet.
        sample();
        check_output("reset_c_gnt", a_c_gnt, 1'b0);
        check_output("reset_outputs_a",
                     {a_d_gnt, a_c_done, a_d_done, a_mem_en, a_mem_we, a_busy}, 6'b0);
        check_output("reset_mem_addr", a_mem_addr, 32'h0);
        check_output("reset_mem_wdata", a_mem_wdata, 32'h0);
        check_output("reset_rdata", {a_c_rdata, a_d_rdata}, 64'h0);
        check_output("reset_outputs_b", {b_c_gnt, b_d_gnt, b_mem_en, b_busy}, 4'b0);
        next_cycle();
        rstn    = 1'b1;
        a_c_req = 1'b0;

        $display("[TB] single-requester accesses, latency 1");
        a_access(1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF);
        a_access(1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'h0);
        a_access(1'b0, 1'b0, 32'h20, 32'h0,         32'h1234_5678);
        a_access(1'b0, 1'b1, 32'h30, 32'h0BAD_F00D, 32'h0);
        a_access(1'b1, 1'b0, 32'h30, 32'h0,         32'h0BAD_F00D);

        $display("[TB] tie, core drops after grant");
        pulse_reset();
        next_cycle();
        a_c_req = 1'b1; a_c_we = 1'b0; a_c_addr = 32'h10;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h20;
        sb_push(1'b0, 32'hDEAD_BEEF);
        sb_push(1'b1, 32'h1234_5678);
        sample();
        check_output("tie1_c_gnt", a_c_gnt, 1'b1);
        check_output("tie1_d_gnt", a_d_gnt, 1'b0);
        next_cycle();
        a_c_req = 1'b0;
        sample();
        check_output("tie1_issue_no_gnt", {a_c_gnt, a_d_gnt}, 2'b00);
        check_output("tie1_issue_addr", a_mem_addr, 32'h10);
        next_cycle();
        sample();
        check_output("tie1_c_done", a_c_done, 1'b1);
        check_output("tie1_done_no_gnt", a_d_gnt, 1'b0);
        next_cycle();
        sample();
        check_output("tie1_d_gnt_c3", a_d_gnt, 1'b1);
        check_output("tie1_c_gnt_c3", a_c_gnt, 1'b0);
        next_cycle();
        a_d_req = 1'b0;
        sample();
        check_output("tie1_d_issue_addr", a_mem_addr, 32'h20);
        next_cycle();
        sample();
        check_output("tie1_d_done_c5", a_d_done, 1'b1);
        next_cycle();
        sample();
        check_output("tie1_idle", a_busy, 1'b0);

        $display("[TB] three back-to-back ties");
        pulse_reset();
        next_cycle();
        a_c_req = 1'b1; a_c_we = 1'b0; a_c_addr = 32'h10;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h20;
        for (int k = 0; k < 3; k++) begin
            sb_push(exp_winner[k], exp_winner[k] ? 32'h1234_5678 : 32'hDEAD_BEEF);
            sample();
            check_output("tie3_c_gnt", a_c_gnt, !exp_winner[k]);
            check_output("tie3_d_gnt", a_d_gnt, exp_winner[k]);
            next_cycle();
            if (k == 2) begin
                a_c_req = 1'b0;
                a_d_req = 1'b0;
            end
            sample();
            check_output("tie3_issue_no_gnt", {a_c_gnt, a_d_gnt}, 2'b00);
            next_cycle();
            sample();
            check_output("tie3_c_done", a_c_done, !exp_winner[k]);
            check_output("tie3_d_done", a_d_done, exp_winner[k]);
            next_cycle();
        end
        sample();
        check_output("tie3_idle", {a_busy, a_c_gnt, a_d_gnt}, 3'b000);
        check_output("sb_drained", sb_q.size(), 0);

        $display("[TB] latency 3 core read");
        next_cycle();
        b_c_req = 1'b1; b_c_we = 1'b0; b_c_addr = 32'h40;
        sample();
        check_output("l3_c_gnt", b_c_gnt, 1'b1);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            next_cycle();
            if (cyc == 1) b_c_req = 1'b0;
            sample();
            check_output("l3_mem_en", b_mem_en, (cyc == 1));
            check_output("l3_busy", b_busy, (cyc <= 4));
            check_output("l3_c_done", b_c_done, (cyc == 4));
            check_output("l3_c_rdata", b_c_rdata, (cyc == 4) ? 32'hCAFE_0040 : 32'h0);
            if (cyc == 1) check_output("l3_mem_addr", b_mem_addr, 32'h40);
        end

        $display("[TB] reset during wait");
        next_cycle();
        b_c_req = 1'b1; b_c_addr = 32'h44;
        sample();
        check_output("rw_c_gnt", b_c_gnt, 1'b1);
        next_cycle();
        b_c_req = 1'b0;
        sample();
        check_output("rw_issue", b_mem_en, 1'b1);
        next_cycle();
        sample();
        check_output("rw_in_wait", {b_busy, b_mem_en}, 2'b10);
        #1;
        rstn    = 1'b0;
        b_c_req = 1'b1;
        #1;
        check_output("rw_rst_ctrl",
                     {b_c_gnt, b_d_gnt, b_c_done, b_d_done, b_mem_en, b_mem_we, b_busy}, 7'b0);
        check_output("rw_rst_addr", b_mem_addr, 32'h0);
        check_output("rw_rst_rdata", {b_c_rdata, b_d_rdata}, 64'h0);
        next_cycle();
        sample();
        check_output("rw_held_no_gnt", {b_c_gnt, b_busy}, 2'b00);
        next_cycle();
        rstn    = 1'b1;
        b_c_req = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            sample();
            check_output("rw_no_done", {b_c_done, b_busy}, 2'b00);
            next_cycle();
        end
        b_c_req = 1'b1; b_c_addr = 32'h48;
        sample();
        check_output("rw_new_gnt", b_c_gnt, 1'b1);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            next_cycle();
            if (cyc == 1) b_c_req = 1'b0;
            sample();
            check_output("rw_new_done", b_c_done, (cyc == 4));
            if (cyc == 4) check_output("rw_new_rdata", b_c_rdata, 32'hCAFE_0048);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
